// File: rtl/replay_timer.sv
// -----------------------------------------------------------------------------
// replay_timer
//   Data-link-layer replay timer and REPLAY_NUM tracker for the replay buffer.
//   It tracks transmitted TLPs that have not been acknowledged yet. When no
//   acknowledgement arrives in time, it times out. It also checks the sequence
//   numbers carried by incoming ACK/NAK DLLPs.
//
// Parameters
//   TIMEOUT  replay timer expiry, in clk cycles of counting (>= 2)
//   SEQ_W    sequence number width; all sequence arithmetic is mod 2^SEQ_W
//   NUM_W    REPLAY_NUM width; rollover after 2^NUM_W replays
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   tlp_sent     pulse: TLP with sequence next_tx_seq-1 has just been sent
//   next_tx_seq  sequence number the transmitter will assign next
//   ack_nack     01=ACK, 10=NAK, 00=none, 11=reserved (ignored)
//   ack_seq      AckNak_Seq_Num, meaningful only while ack_nack != 00
//   replay_done  pulse: replay buffer has finished retransmitting
//   tim_out      one-cycle pulse on timer expiry
//   retrain      one-cycle pulse on REPLAY_NUM rollover
//   dllp_err     one-cycle pulse on an ACK/NAK with an out-of-window ack_seq
//   outstanding  1 while any unacknowledged TLP exists (combinational)
//   acked_seq    last acknowledged sequence number
//   replay_num   current REPLAY_NUM
// -----------------------------------------------------------------------------
module replay_timer #(
   parameter int unsigned TIMEOUT = 711,
   parameter int unsigned SEQ_W   = 12,
   parameter int unsigned NUM_W   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tlp_sent,
   input  logic [SEQ_W-1:0] next_tx_seq,
   input  logic [1:0]       ack_nack,
   input  logic [SEQ_W-1:0] ack_seq,
   input  logic             replay_done,
   output logic             tim_out,
   output logic             retrain,
   output logic             dllp_err,
   output logic             outstanding,
   output logic [SEQ_W-1:0] acked_seq,
   output logic [NUM_W-1:0] replay_num
);

   localparam int unsigned      CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      REPLAY = 2'd2
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] count, count_d;
   logic [SEQ_W-1:0] acked_d;
   logic [NUM_W-1:0] replay_num_d, rn_base;
   logic             tim_out_d, retrain_d, dllp_err_d;

   // Sequence-window arithmetic. Every difference is taken mod 2^SEQ_W, so a
   // wrap of the sequence space needs no special case.
   logic [SEQ_W-1:0] last_seq;     // newest transmitted sequence number
   logic [SEQ_W-1:0] n_out;        // TLPs outstanding before this cycle's DLLP
   logic [SEQ_W-1:0] d_ack;        // distance of ack_seq past acked_seq
   logic [SEQ_W-1:0] new_acked;    // acked_seq after this cycle's DLLP
   logic             is_ack, is_nak, dllp_vld, in_window;
   logic             progress, ack_progress, nak_ok;
   logic             out_after, expire, replay_evt;

   always_comb begin
      last_seq     = next_tx_seq - 1'b1;
      n_out        = last_seq - acked_seq;
      d_ack        = ack_seq - acked_seq;
      is_ack       = (ack_nack == 2'b01);
      is_nak       = (ack_nack == 2'b10);
      dllp_vld     = is_ack | is_nak;
      in_window    = (d_ack <= n_out);
      progress     = dllp_vld & in_window & (d_ack != '0);
      ack_progress = is_ack & progress;
      // A duplicate NAK (d == 0) still triggers a replay.
      nak_ok       = is_nak & in_window;
      new_acked    = progress ? ack_seq : acked_seq;
      // A TLP sent in the same cycle is already reflected in next_tx_seq.
      out_after    = ((last_seq - new_acked) != '0);
      // A progress ACK on the expiry cycle wins over the timeout.
      expire       = (state == RUN) & (count == CNT_MAX) & ~ack_progress;
      replay_evt   = (state == RUN) & (nak_ok | expire);
   end

   assign outstanding = ~rst & (n_out != '0);

   // State register and all registered outputs.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         acked_seq  <= '1;
         replay_num <= '0;
         tim_out    <= 1'b0;
         retrain    <= 1'b0;
         dllp_err   <= 1'b0;
      end else begin
         state      <= state_d;
         count      <= count_d;
         acked_seq  <= acked_d;
         replay_num <= replay_num_d;
         tim_out    <= tim_out_d;
         retrain    <= retrain_d;
         dllp_err   <= dllp_err_d;
      end
   end

   // Next-state logic.
   // NOTE: the default at the top of a combinational block guarantees that
   // every path assigns a value, so no latch is inferred.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (tlp_sent) state_d = RUN;
         RUN: begin
            if (replay_evt)                     state_d = REPLAY;
            else if (ack_progress && !out_after) state_d = IDLE;
         end
         REPLAY:  if (replay_done) state_d = out_after ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for the counter and the registered outputs.
   always_comb begin
      count_d = '0;
      if (state == RUN && !replay_evt && !ack_progress)
         count_d = count + 1'b1;

      acked_d = new_acked;

      // Forward progress clears REPLAY_NUM before any increment in the same
      // cycle, so a NAK with progress leaves it at 1.
      rn_base      = progress ? '0 : replay_num;
      replay_num_d = replay_evt ? rn_base + 1'b1 : rn_base;
      retrain_d    = replay_evt & (rn_base == '1);

      tim_out_d  = expire & ~nak_ok;
      dllp_err_d = dllp_vld & ~in_window;
   end

endmodule

// File: tb/tb_replay_timer.sv
// -----------------------------------------------------------------------------
// tb_replay_timer
//   Self-checking bench for replay_timer (TIMEOUT=16, SEQ_W=12, NUM_W=2).
//   Stimulus pushes each expected pulse event (cycle, tim_out/retrain/dllp_err,
//   replay_num) into a queue. A monitor pops an entry whenever the DUT pulses
//   an output and compares the two. Static state is checked inline.
// -----------------------------------------------------------------------------
module tb_replay_timer;

   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned SEQ_W   = 12;
   localparam int unsigned NUM_W   = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             tlp_sent = 1'b0;
   logic [SEQ_W-1:0] next_tx_seq = '0;
   logic [1:0]       ack_nack = 2'b00;
   logic [SEQ_W-1:0] ack_seq = '0;
   logic             replay_done = 1'b0;
   logic             tim_out, retrain, dllp_err, outstanding;
   logic [SEQ_W-1:0] acked_seq;
   logic [NUM_W-1:0] replay_num;

   replay_timer #(.TIMEOUT(TIMEOUT), .SEQ_W(SEQ_W), .NUM_W(NUM_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .tlp_sent    (tlp_sent),
      .next_tx_seq (next_tx_seq),
      .ack_nack    (ack_nack),
      .ack_seq     (ack_seq),
      .replay_done (replay_done),
      .tim_out     (tim_out),
      .retrain     (retrain),
      .dllp_err    (dllp_err),
      .outstanding (outstanding),
      .acked_seq   (acked_seq),
      .replay_num  (replay_num)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      int         cyc;
      logic       tim;
      logic       ret;
      logic       err;
      logic [1:0] rn;
   } evt_t;

   evt_t exp_q[$];

   localparam logic [1:0] AN_NONE = 2'b00, AN_ACK = 2'b01, AN_NAK = 2'b10, AN_RSV = 2'b11;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
      vectors++;
      if (actual !== required) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   task automatic expect_evt(input int c, input logic t, input logic r, input logic e,
                             input logic [1:0] rn);
      evt_t ev;
      ev.cyc = c; ev.tim = t; ev.ret = r; ev.err = e; ev.rn = rn;
      exp_q.push_back(ev);
   endtask

   // Monitor: pop one expected event per output pulse and flag expected
   // events whose cycle has passed without a pulse.
   always @(negedge clk) begin
      evt_t ev;
      if (!rst) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            vectors++;
            errors++;
            $display("FAIL missed_event: pulse expected at cycle %0d, no pulse observed by cycle %0d",
                     exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
         end
         if (tim_out || retrain || dllp_err) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_pulse: tim_out=%0b retrain=%0b dllp_err=%0b at cycle %0d, expected none",
                        tim_out, retrain, dllp_err, cyc);
            end else begin
               ev = exp_q.pop_front();
               check("event_cycle", cyc, ev.cyc);
               check("event_tim_ret_err_rn", {tim_out, retrain, dllp_err, replay_num},
                     {ev.tim, ev.ret, ev.err, ev.rn});
            end
         end
      end
   end

   // Apply one cycle of inputs at a negedge and return at the next negedge.
   task automatic drive(input logic s, input logic [SEQ_W-1:0] nts, input logic [1:0] an,
                        input logic [SEQ_W-1:0] as, input logic rd);
      tlp_sent = s; next_tx_seq = nts; ack_nack = an; ack_seq = as; replay_done = rd;
      @(negedge clk);
      tlp_sent = 1'b0; ack_nack = AN_NONE; replay_done = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      tlp_sent = 1'b0; next_tx_seq = '0; ack_nack = AN_NONE; ack_seq = '0; replay_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   int c;

   initial begin
      // ---------------- Test 1 + 3: repeated timeouts, REPLAY_NUM rollover
      do_reset();
      check("reset_acked_seq", acked_seq, 32'hFFF);
      check("reset_replay_num", replay_num, 0);
      check("reset_pulses", {tim_out, retrain, dllp_err}, 0);
      check("reset_outstanding", outstanding, 0);

      c = cyc;
      expect_evt(c + 17, 1'b1, 1'b0, 1'b0, 2'd1);
      drive(1'b1, 12'h001, AN_NONE, '0, 1'b0);
      check("t1_outstanding", outstanding, 1);
      wait_until(c + 17);
      for (int k = 2; k <= 4; k++) begin
         c = cyc;
         expect_evt(c + 17, 1'b1, (k == 4), 1'b0, 2'(k % 4));
         drive(1'b0, 12'h001, AN_NONE, '0, 1'b1);
         wait_until(c + 17);
      end
      drive(1'b0, 12'h001, AN_ACK, 12'h000, 1'b0);
      check("t3_acked_seq", acked_seq, 12'h000);
      check("t3_outstanding", outstanding, 0);
      drive(1'b0, 12'h001, AN_NONE, '0, 1'b1);
      repeat (20) @(negedge clk);

      // ---------------- Test 2: progress ACK restarts the timer
      do_reset();
      c = cyc;
      for (int i = 1; i <= 4; i++) drive(1'b1, 12'(i), AN_NONE, '0, 1'b0);
      wait_until(c + 9);
      drive(1'b0, 12'h004, AN_ACK, 12'h001, 1'b0);
      check("t2_acked_seq_1", acked_seq, 12'h001);
      check("t2_outstanding_1", outstanding, 1);
      check("t2_replay_num", replay_num, 0);
      wait_until(c + 20);
      drive(1'b0, 12'h004, AN_ACK, 12'h003, 1'b0);
      check("t2_acked_seq_3", acked_seq, 12'h003);
      check("t2_outstanding_0", outstanding, 0);
      repeat (30) @(negedge clk);

      // ---------------- Test 4: sequence wrap and out-of-window ACK
      do_reset();
      drive(1'b0, 12'hFFF, AN_ACK, 12'hFFE, 1'b0);
      check("t4_acked_fffe", acked_seq, 12'hFFE);
      drive(1'b1, 12'h002, AN_NONE, '0, 1'b0);
      check("t4_outstanding_wrap", outstanding, 1);
      drive(1'b0, 12'h002, AN_ACK, 12'h001, 1'b0);
      check("t4_acked_wrap", acked_seq, 12'h001);
      check("t4_outstanding_0", outstanding, 0);
      expect_evt(cyc + 1, 1'b0, 1'b0, 1'b1, 2'd0);
      drive(1'b0, 12'h002, AN_ACK, 12'h800, 1'b0);
      check("t4_acked_unchanged", acked_seq, 12'h001);
      // Out-of-window ACK while running must not disturb the timer.
      c = cyc;
      drive(1'b1, 12'h005, AN_NONE, '0, 1'b0);
      wait_until(c + 3);
      expect_evt(c + 4, 1'b0, 1'b0, 1'b1, 2'd0);
      expect_evt(c + 17, 1'b1, 1'b0, 1'b0, 2'd1);
      drive(1'b0, 12'h005, AN_ACK, 12'h800, 1'b0);
      check("t4_acked_unchanged_run", acked_seq, 12'h001);
      wait_until(c + 20);

      // ---------------- Test 5: ACK beats expiry, duplicate NAK, NAK with progress
      do_reset();
      c = cyc;
      drive(1'b1, 12'h004, AN_NONE, '0, 1'b0);
      wait_until(c + 16);
      drive(1'b0, 12'h004, AN_ACK, 12'h002, 1'b0);
      check("t5_acked_2", acked_seq, 12'h002);
      check("t5_outstanding", outstanding, 1);
      drive(1'b0, 12'h004, AN_NAK, 12'h002, 1'b0);
      check("t5_nak_replay_num", replay_num, 1);
      repeat (20) @(negedge clk);
      c = cyc;
      expect_evt(c + 17, 1'b1, 1'b0, 1'b0, 2'd2);
      drive(1'b0, 12'h004, AN_NONE, '0, 1'b1);
      wait_until(c + 17);
      drive(1'b0, 12'h004, AN_NONE, '0, 1'b1);
      drive(1'b0, 12'h004, AN_NAK, 12'h003, 1'b0);
      check("t5_nak_prog_acked", acked_seq, 12'h003);
      check("t5_nak_prog_replay_num", replay_num, 1);
      check("t5_nak_prog_outstanding", outstanding, 0);
      drive(1'b0, 12'h004, AN_NONE, '0, 1'b1);
      drive(1'b0, 12'h004, AN_RSV, 12'h800, 1'b0);
      repeat (20) @(negedge clk);

      // ---------------- Test 6: asynchronous reset mid-RUN
      do_reset();
      c = cyc;
      expect_evt(c + 17, 1'b1, 1'b0, 1'b0, 2'd1);
      drive(1'b1, 12'h001, AN_NONE, '0, 1'b0);
      wait_until(c + 17);
      c = cyc;
      expect_evt(c + 17, 1'b1, 1'b0, 1'b0, 2'd2);
      drive(1'b0, 12'h001, AN_NONE, '0, 1'b1);
      wait_until(c + 17);
      c = cyc;
      drive(1'b0, 12'h001, AN_NONE, '0, 1'b1);
      wait_until(c + 10);
      check("t6_pre_replay_num", replay_num, 2);
      #1 rst = 1'b1;
      #1;
      check("t6_async_acked_seq", acked_seq, 32'hFFF);
      check("t6_async_replay_num", replay_num, 0);
      check("t6_async_pulses", {tim_out, retrain, dllp_err}, 0);
      check("t6_async_outstanding", outstanding, 0);
      @(negedge clk);
      rst = 1'b0;
      c = cyc;
      expect_evt(c + 17, 1'b1, 1'b0, 1'b0, 2'd1);
      drive(1'b1, 12'h001, AN_NONE, '0, 1'b0);
      wait_until(c + 20);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
